// File: rtl/wm_cycle_ctrl_if.sv
// wm_cycle_ctrl_if: panel commands and indicator lines of the washing-machine sequencer.
// lid_open is present only when WM_LID_LOCK_EN is defined.
interface wm_cycle_ctrl_if;
    logic       start;
    logic       pause;
    logic [1:0] water_sel;
    logic [1:0] temp_sel;
    logic [1:0] rinse_cnt;
`ifdef WM_LID_LOCK_EN
    logic       lid_open;
`endif
    logic       led_wash, led_rinse, led_dry, led_repeat;
    logic       led_water_high, led_water_mid, led_water_low;
    logic       led_hot_only, led_cold_only, led_hot_cold;
    logic       busy;
    logic       done;
    logic [7:0] sec_left;

    modport master (
        output start, pause, water_sel, temp_sel, rinse_cnt,
`ifdef WM_LID_LOCK_EN
        output lid_open,
`endif
        input  led_wash, led_rinse, led_dry, led_repeat,
        input  led_water_high, led_water_mid, led_water_low,
        input  led_hot_only, led_cold_only, led_hot_cold,
        input  busy, done, sec_left
    );

    modport slave (
        input  start, pause, water_sel, temp_sel, rinse_cnt,
`ifdef WM_LID_LOCK_EN
        input  lid_open,
`endif
        output led_wash, led_rinse, led_dry, led_repeat,
        output led_water_high, led_water_mid, led_water_low,
        output led_hot_only, led_cold_only, led_hot_cold,
        output busy, done, sec_left
    );
endinterface

// File: rtl/wm_cycle_ctrl.sv
// wm_cycle_ctrl: washing-machine course sequencer (fill/wash/drain/rinse/dry) on a seconds timebase.
// Defining WM_LID_LOCK_EN adds the lid interlock (refuse start, force pause while the lid is open).
module wm_cycle_ctrl #(
    parameter int TICK_DIV      = 125000000,
    parameter int FILL_LOW_SEC  = 2,
    parameter int FILL_MID_SEC  = 3,
    parameter int FILL_HIGH_SEC = 4,
    parameter int WASH_SEC      = 10,
    parameter int RINSE_SEC     = 6,
    parameter int DRAIN_SEC     = 2,
    parameter int DRY_SEC       = 8
) (
    input logic            clk,
    input logic            rstn,
    wm_cycle_ctrl_if.slave io
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;

    typedef enum logic [3:0] {IDLE, FILL_W, WASH, DRAIN_W, FILL_R, RINSE, DRAIN_R, DRY, DONE} state_t;

    state_t        state_q, state_d, nxt;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    sec_left_q, sec_left_d;
    logic [1:0]    rinse_left_q, rinse_left_d, water_q, water_d, temp_q, temp_d;
    logic          paused_q, paused_d, busy_q, busy_d, done_q, done_d;
    logic [3:0]    phase_q, phase_d;
    logic [2:0]    wlvl_q, wlvl_d, tmp_q, tmp_d;
    logic [1:0]    wsrc, tsrc;
    logic          lid, idle, run, tick, go, rinse_ph;

`ifdef WM_LID_LOCK_EN
    assign lid = io.lid_open;
`else
    assign lid = 1'b0;
`endif

    function automatic logic [7:0] dur(input state_t s, input logic [1:0] w);
        logic [7:0] fill;
        fill = w == 2'd0 ? 8'(FILL_LOW_SEC) : w == 2'd1 ? 8'(FILL_MID_SEC) : 8'(FILL_HIGH_SEC);
        return s inside {FILL_W, FILL_R}   ? fill :
               s == WASH                   ? 8'(WASH_SEC) :
               s == RINSE                  ? 8'(RINSE_SEC) :
               s inside {DRAIN_W, DRAIN_R} ? 8'(DRAIN_SEC) :
               s == DRY                    ? 8'(DRY_SEC) : 8'd0;
    endfunction

    always_comb begin
        idle = state_q == IDLE || state_q == DONE;
        run  = !idle && !paused_q;
        tick = run && presc_q == PW'(TICK_DIV - 1);
        go   = idle && io.start && !lid;
        // states FILL_W..RINSE are enumerated in course order, so those simply step forward
        nxt  = state_q == DRAIN_R ? (rinse_left_q > 2'd1 ? FILL_R : DRY) :
               state_q == DRY     ? DONE : state_t'(state_q + 4'd1);
        state_d      = state_q;
        presc_d      = presc_q;
        sec_left_d   = sec_left_q;
        rinse_left_d = rinse_left_q;
        water_d      = water_q;
        temp_d       = temp_q;
        if (go) begin
            state_d      = FILL_W;
            presc_d      = '0;
            water_d      = io.water_sel;
            temp_d       = io.temp_sel;
            rinse_left_d = io.rinse_cnt == 2'd0 ? 2'd1 : io.rinse_cnt;
            sec_left_d   = dur(FILL_W, io.water_sel);
        end else if (run) begin
            presc_d    = tick ? '0 : presc_q + PW'(1);
            sec_left_d = sec_left_q - {7'd0, tick};
            if (tick && sec_left_q == 8'd1) begin
                state_d    = nxt;
                sec_left_d = dur(nxt, water_q);
                if (state_q == DRAIN_R && rinse_left_q > 2'd1)
                    rinse_left_d = rinse_left_q - 2'd1;
            end
        end
        paused_d = !idle && (lid || (paused_q ^ io.pause));
        busy_d   = !(state_d == IDLE || state_d == DONE);
        done_d   = state_d == DONE;
        rinse_ph = state_d inside {FILL_R, RINSE, DRAIN_R};
        phase_d  = {state_d inside {FILL_W, WASH, DRAIN_W}, rinse_ph, state_d == DRY,
                    rinse_ph && rinse_left_d > 2'd1};
        wsrc     = busy_d ? water_d : io.water_sel;
        tsrc     = busy_d ? temp_d : io.temp_sel;
        wlvl_d   = {wsrc[1], wsrc == 2'd1, wsrc == 2'd0};
        tmp_d    = {tsrc == 2'd1, tsrc[0] == tsrc[1], tsrc == 2'd2};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            presc_q      <= '0;
            sec_left_q   <= '0;
            rinse_left_q <= '0;
            water_q      <= '0;
            temp_q       <= '0;
            paused_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            phase_q      <= '0;
            wlvl_q       <= '0;
            tmp_q        <= '0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            sec_left_q   <= sec_left_d;
            rinse_left_q <= rinse_left_d;
            water_q      <= water_d;
            temp_q       <= temp_d;
            paused_q     <= paused_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            phase_q      <= phase_d;
            wlvl_q       <= wlvl_d;
            tmp_q        <= tmp_d;
        end
    end

    assign {io.led_wash, io.led_rinse, io.led_dry, io.led_repeat} = phase_q;
    assign {io.led_water_high, io.led_water_mid, io.led_water_low} = wlvl_q;
    assign {io.led_hot_only, io.led_cold_only, io.led_hot_cold}    = tmp_q;
    assign io.busy     = busy_q;
    assign io.done     = done_q;
    assign io.sec_left = sec_left_q;
endmodule

// File: tb/tb_wm_cycle_ctrl.sv
// tb_wm_cycle_ctrl: scoreboard bench for wm_cycle_ctrl at TICK_DIV=4 (one expected vector per cycle).
// The lid interlock scenario is built only when WM_LID_LOCK_EN is defined.
module tb_wm_cycle_ctrl;
    logic clk  = 1'b0;
    logic rstn = 1'b1;
    int n_vec = 0;
    int n_bad = 0;
    logic [19:0] exp_q[$];
    int pause_a, pause_b, start_at, chg_at, stop_at, lid_on, lid_off, done_idx;
    logic [1:0] new_w, new_t, new_r;
    int pidx, fz_at_g, fz_len_g;
    logic [5:0] cur_wt;

    wm_cycle_ctrl_if ifc();

    wm_cycle_ctrl #(.TICK_DIV(4)) dut (.clk(clk), .rstn(rstn), .io(ifc));

    always #4 clk = ~clk;

    // vector layout: busy, done, wash, rinse, dry, repeat, w_high, w_mid, w_low, hot, cold, hot_cold, sec_left
    function automatic logic [19:0] obs();
        return {ifc.busy, ifc.done, ifc.led_wash, ifc.led_rinse, ifc.led_dry, ifc.led_repeat,
                ifc.led_water_high, ifc.led_water_mid, ifc.led_water_low,
                ifc.led_hot_only, ifc.led_cold_only, ifc.led_hot_cold, ifc.sec_left};
    endfunction

    function automatic logic [5:0] wt(input logic [1:0] w, input logic [1:0] t);
        logic [2:0] wl, tl;
        case (w)
            2'd0:    wl = 3'b001;
            2'd1:    wl = 3'b010;
            default: wl = 3'b100;
        endcase
        case (t)
            2'd1:    tl = 3'b100;
            2'd2:    tl = 3'b001;
            default: tl = 3'b010;
        endcase
        return {wl, tl};
    endfunction

    task automatic push_phase(input logic [3:0] ph, input int d);
        logic [19:0] e;
        for (int k = 0; k < d * 4; k++) begin
            e = {2'b10, ph, cur_wt, 8'(d - k / 4)};
            exp_q.push_back(e);
            if (pidx == fz_at_g) repeat (fz_len_g) exp_q.push_back(e);
            pidx++;
        end
    endtask

    task automatic push_course(input logic [1:0] w, input logic [1:0] t, input logic [1:0] r,
                               input logic [1:0] dw, input logic [1:0] dt, input int ndone,
                               input int fz_at, input int fz_len);
        int fill, nr;
        logic [3:0] ph;
        fill = w == 2'd0 ? 2 : w == 2'd1 ? 3 : 4;
        nr = r == 2'd0 ? 1 : int'(r);
        pidx = 0;
        fz_at_g = fz_at;
        fz_len_g = fz_len;
        cur_wt = wt(w, t);
        push_phase(4'b1000, fill);
        push_phase(4'b1000, 10);
        push_phase(4'b1000, 2);
        for (int j = 0; j < nr; j++) begin
            ph = {3'b010, j < nr - 1};
            push_phase(ph, fill);
            push_phase(ph, 6);
            push_phase(ph, 2);
        end
        push_phase(4'b0010, 8);
        repeat (ndone) exp_q.push_back({2'b01, 4'b0000, wt(dw, dt), 8'd0});
    endtask

    task automatic clr();
        pause_a = -1; pause_b = -1; start_at = -1; chg_at = -1; stop_at = -1;
        lid_on = -1; lid_off = -1;
        exp_q.delete();
    endtask

    task automatic kick(input logic [1:0] w, input logic [1:0] t, input logic [1:0] r, input logic p);
        ifc.water_sel = w;
        ifc.temp_sel = t;
        ifc.rinse_cnt = r;
        ifc.start = 1'b1;
        ifc.pause = p;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        ifc.pause = 1'b0;
    endtask

    task automatic run_q(input string tag);
        logic [19:0] e, o;
        done_idx = -1;
        for (int i = 0; exp_q.size() > 0 && i != stop_at; i++) begin
            e = exp_q.pop_front();
            o = obs();
            n_vec++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL %s cycle %0d: got %h want %h", tag, i, o, e);
            end
            if (o[18] && done_idx < 0) done_idx = i;
            ifc.pause = i == pause_a || i == pause_b;
            ifc.start = i == start_at;
            if (i == chg_at) begin
                ifc.water_sel = new_w;
                ifc.temp_sel = new_t;
                ifc.rinse_cnt = new_r;
            end
`ifdef WM_LID_LOCK_EN
            ifc.lid_open = i >= lid_on && i < lid_off;
`endif
            @(posedge clk);
            #1;
        end
        ifc.pause = 1'b0;
        ifc.start = 1'b0;
    endtask

    task automatic test_reset();
        logic [19:0] e;
        #2 rstn = 1'b0;
        #1;
        n_vec++;
        if (obs() !== 20'd0) begin n_bad++; $display("FAIL reset_async: got %h want 0", obs()); end
        @(posedge clk);
        #1;
        n_vec++;
        if (obs() !== 20'd0) begin n_bad++; $display("FAIL reset_hold: got %h want 0", obs()); end
        rstn = 1'b1;
        @(posedge clk);
        #1;
        e = {6'b0, wt(2'd1, 2'd2), 8'd0};
        n_vec++;
        if (obs() !== e) begin n_bad++; $display("FAIL idle_live: got %h want %h", obs(), e); end
    endtask

    task automatic test_basic();
        clr();
        push_course(2'd0, 2'd1, 2'd1, 2'd0, 2'd1, 3, -1, 0);
        kick(2'd0, 2'd1, 2'd1, 1'b1);
        run_q("basic");
        n_vec++;
        if (done_idx !== 128) begin n_bad++; $display("FAIL basic_done_time: got %0d want 128", done_idx); end
    endtask

    task automatic test_multi_rinse();
        clr();
        push_course(2'd2, 2'd2, 2'd3, 2'd2, 2'd2, 2, -1, 0);
        kick(2'd2, 2'd2, 2'd3, 1'b0);
        run_q("multi_rinse");
        n_vec++;
        if (done_idx !== 240) begin n_bad++; $display("FAIL multi_done_time: got %0d want 240", done_idx); end
    endtask

    task automatic test_pause();
        clr();
        push_course(2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2, 29, 100);
        pause_a = 28;
        pause_b = 128;
        kick(2'd0, 2'd0, 2'd0, 1'b0);
        run_q("pause");
    endtask

    task automatic test_settings_change();
        logic [19:0] e;
        clr();
        push_course(2'd1, 2'd2, 2'd1, 2'd0, 2'd1, 1, -1, 0);
        chg_at = 50;
        new_w = 2'd0;
        new_t = 2'd1;
        new_r = 2'd0;
        kick(2'd1, 2'd2, 2'd1, 1'b0);
        run_q("settings");
        ifc.water_sel = 2'd3;
        ifc.temp_sel = 2'd3;
        @(posedge clk);
        #1;
        e = {6'b010000, wt(2'd3, 2'd3), 8'd0};
        n_vec++;
        if (obs() !== e) begin n_bad++; $display("FAIL done_live: got %h want %h", obs(), e); end
    endtask

    task automatic test_start_ignored_reset();
        clr();
        push_course(2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 0, -1, 0);
        start_at = 70;
        stop_at = 110;
        kick(2'd0, 2'd0, 2'd1, 1'b0);
        run_q("start_ignored");
        #2 rstn = 1'b0;
        #1;
        n_vec++;
        if (obs() !== 20'd0) begin n_bad++; $display("FAIL reset_mid_dry: got %h want 0", obs()); end
        exp_q.delete();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        clr();
        push_course(2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 1, -1, 0);
        push_course(2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2, -1, 0);
        chg_at = 180;
        start_at = 180;
        new_w = 2'd2;
        new_t = 2'd1;
        new_r = 2'd0;
        kick(2'd1, 2'd0, 2'd2, 1'b0);
        run_q("back_to_back");
    endtask

`ifdef WM_LID_LOCK_EN
    task automatic test_lid();
        logic [19:0] e;
        clr();
        ifc.lid_open = 1'b1;
        ifc.start = 1'b1;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        ifc.lid_open = 1'b0;
        e = {6'b010000, wt(2'd2, 2'd1), 8'd0};
        n_vec++;
        if (obs() !== e) begin n_bad++; $display("FAIL lid_start_refused: got %h want %h", obs(), e); end
        push_course(2'd0, 2'd1, 2'd1, 2'd0, 2'd1, 2, 29, 50);
        lid_on = 28;
        lid_off = 58;
        pause_a = 38;
        pause_b = 78;
        kick(2'd0, 2'd1, 2'd1, 1'b0);
        run_q("lid");
    endtask
`endif

    initial begin
        ifc.start = 1'b0;
        ifc.pause = 1'b0;
        ifc.water_sel = 2'd1;
        ifc.temp_sel = 2'd2;
        ifc.rinse_cnt = 2'd0;
`ifdef WM_LID_LOCK_EN
        ifc.lid_open = 1'b0;
`endif
        test_reset();
        test_basic();
        test_multi_rinse();
        test_pause();
        test_settings_change();
        test_start_ignored_reset();
        test_back_to_back();
`ifdef WM_LID_LOCK_EN
        test_lid();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/wm_cycle_ctrl.md
Name: wm_cycle_ctrl

Overview:
Washing-machine cycle sequencer that steps through the fill, wash, drain, rinse (repeatable) and dry phases on a seconds timebase. It drives the phase, water-level and temperature indicator lines consumed by wm_led_top. It latches the user course settings at start and exposes busy/done and the remaining seconds of the current phase. It sits between the panel inputs and the LED block.

Parameters:
TICK_DIV, 125000000, clk cycles per 1 s tick (8 ns clk); bench uses 4
FILL_LOW_SEC, 2, fill duration, low water
FILL_MID_SEC, 3, fill duration, mid water
FILL_HIGH_SEC, 4, fill duration, high water
WASH_SEC, 10, wash duration
RINSE_SEC, 6, duration of one rinse
DRAIN_SEC, 2, duration of each drain
DRY_SEC, 8, spin/dry duration

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
start  in  1  1-cycle pulse; begins a course
pause  in  1  1-cycle pulse; toggles pause while busy
water_sel  in  2  0 low, 1 mid, 2 high, 3 = high
temp_sel  in  2  0 cold only, 1 hot only, 2 hot+cold, 3 = cold only
rinse_cnt  in  2  number of rinses; 0 = 1
lid_open  in  1  only when WM_LID_LOCK_EN defined
led_wash, led_rinse, led_dry, led_repeat  out  1 each  phase indicators
led_water_high, led_water_mid, led_water_low  out  1 each  one-hot water level
led_hot_only, led_cold_only, led_hot_cold  out  1 each  one-hot temperature
busy  out  1  course in progress (any state except IDLE/DONE)
done  out  1  course finished
sec_left  out  8  seconds remaining in current phase

Behaviour:
- All outputs registered. Reset: state IDLE, every LED 0, busy 0, done 0, sec_left 0, paused 0, prescaler 0.
- States: IDLE, FILL_W, WASH, DRAIN_W, FILL_R, RINSE, DRAIN_R, DRY, DONE.
- start is accepted only in IDLE or DONE. On acceptance: latch water_sel, temp_sel, rinse_left = max(rinse_cnt,1); go to FILL_W; load sec_left with the fill duration; clear done. start while busy is ignored.
- Prescaler counts 0..TICK_DIV-1 and restarts at 0 on every state entry. Its terminal count produces a 1-cycle tick. Each tick decrements sec_left.
- Phase exit occurs on the tick with sec_left==1. The next state loads its duration on the same edge, so each phase lasts exactly duration*TICK_DIV cycles.
- Transition sequence: FILL_W -> WASH -> DRAIN_W -> FILL_R -> RINSE -> DRAIN_R.
- DRAIN_R exit: if rinse_left>1, decrement rinse_left and go to FILL_R; else go to DRY.
- DRY -> DONE. DONE holds done=1 and sec_left=0 until the next start.
- Fill duration (both fills) is selected by the latched water level.
- Phase LEDs:
  - led_wash in FILL_W/WASH/DRAIN_W.
  - led_rinse in FILL_R/RINSE/DRAIN_R.
  - led_dry in DRY.
  - led_repeat = rinse phase and rinse_left>1.
- Water and temperature LEDs:
  - Track the live selections in IDLE and DONE.
  - Show the latched values while busy. Exactly one of each group is lit, except in reset.
- Pause: a pause pulse while busy toggles paused. While paused, the prescaler and sec_left freeze and all outputs hold. pause in IDLE/DONE is ignored.
- Simultaneous start and pause in IDLE/DONE: start wins, pause is dropped.
- Outputs update one cycle after the input or state change that causes them.
- Reset asserted mid-course forces IDLE asynchronously. Latched settings and paused are cleared.

Optional Feature:
Macro WM_LID_LOCK_EN.
- Defined:
  - The lid_open port exists.
  - start is refused while lid_open=1.
  - lid_open=1 while busy forces paused=1. Pause cannot be cleared while the lid is open.
  - Lid closing does not auto-resume; a pause pulse is required.
- Undefined: the port is absent and the lid logic is removed.

Test Plan:
- TICK_DIV=4, water 0, temp 1, rinse_cnt 1, start pulse at edge N -> busy=1 at N+1. Phase sequence 2/10/2/2/6/2/8 s. done rises 128 cycles after N. led_hot_only=1 throughout.
- rinse_cnt 3, water 2 -> FILL_R/RINSE/DRAIN_R run 3 times. led_repeat=1 in the first two rinse loops only. Total time (4+10+2+3*(4+6+2)+8)*4 = 240 cycles.
- Pause pulse mid-WASH at sec_left=5 -> sec_left holds 5 for 100 cycles. A second pause resumes, and the WASH end is shifted by exactly the paused cycles.
- Change water_sel/temp_sel while busy -> LEDs unchanged. After done, LEDs follow the new live values next cycle.
- start during RINSE -> ignored. rstn low mid-DRY -> all outputs 0 immediately. Start after release runs a full course.
- (WM_LID_LOCK_EN) lid_open=1 with start -> stays IDLE. lid_open in WASH -> frozen. Lid close plus pause pulse resumes.
